// File: rtl/oled_buf_pkg.sv
// Shared constants and FSM state type for the OLED character buffer.
package oled_buf_pkg;

    localparam int unsigned DEPTH      = 64;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned DATA_W     = 8;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

endpackage

// File: rtl/oled_char_buffer_char_ram.sv
// Character storage: register array with one write port, one combinational
// read port and a flag telling whether the pending write changes its cell.
module char_ram #(
    parameter int unsigned       DEPTH  = oled_buf_pkg::DEPTH,
    parameter int unsigned       ADDR_W = oled_buf_pkg::ADDR_W,
    parameter int unsigned       DATA_W = oled_buf_pkg::DATA_W,
    parameter logic [DATA_W-1:0] BLANK  = oled_buf_pkg::BLANK_CHAR
) (
    input  logic              sysclk,
    input  logic              cpu_resetn,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              wdiff_o
);
    import oled_buf_pkg::*;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BLANK;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
    assign wdiff_o = we_i && (mem_q[waddr_i] != wdata_i);

endmodule

// File: rtl/oled_char_buffer.sv
// OLED character buffer: CPU write port, change tracking and a 64-beat
// valid/ready frame streamer feeding the display renderer.
module oled_char_buffer #(
    parameter int unsigned       DEPTH      = oled_buf_pkg::DEPTH,
    parameter int unsigned       DATA_W     = oled_buf_pkg::DATA_W,
    parameter logic [DATA_W-1:0] BLANK_CHAR = oled_buf_pkg::BLANK_CHAR
) (
    input  logic                            sysclk,
    input  logic                            cpu_resetn,
    input  logic                            we_ip,
    input  logic [oled_buf_pkg::ADDR_W-1:0] write_addr_ip,
    input  logic [DATA_W-1:0]               write_data_ip,
    output logic                            stream_valid_op,
    input  logic                            stream_ready_ip,
    output logic [oled_buf_pkg::ADDR_W-1:0] stream_addr_op,
    output logic [DATA_W-1:0]               stream_data_op,
    output logic                            stream_last_op,
    output logic                            busy_op,
    output logic                            dirty_op,
    output logic [15:0]                     frame_count_op
);
    import oled_buf_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic                valid_q;
    logic [DATA_W-1:0]   data_q;
    logic                dirty_q;
    logic [15:0]         frame_q;

    logic [ADDR_W-1:0]   load_addr_d;
    logic [DATA_W-1:0]   load_data_d;
    logic [DATA_W-1:0]   ram_rdata;
    logic                wdiff;
    logic                handshake;

    char_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BLANK  (BLANK_CHAR)
    ) u_ram (
        .sysclk     (sysclk),
        .cpu_resetn (cpu_resetn),
        .we_i       (we_ip),
        .waddr_i    (write_addr_ip),
        .wdata_i    (write_data_ip),
        .raddr_i    (load_addr_d),
        .rdata_o    (ram_rdata),
        .wdiff_o    (wdiff)
    );

    // Cell that would be loaded on this edge; a same-edge write to it bypasses the array.
    always_comb begin
        load_addr_d = (state_q == IDLE) ? '0 : idx_q + 1'b1;
        load_data_d = (we_ip && (write_addr_ip == load_addr_d)) ? write_data_ip : ram_rdata;
    end

    assign handshake = valid_q && stream_ready_ip;

    always_ff @(posedge sysclk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= BLANK_CHAR;
            dirty_q <= 1'b1;
            frame_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Starting a frame clears dirty, but a changing write on the same edge re-sets it.
                    dirty_q <= wdiff;
                    if (dirty_q) begin
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        data_q  <= load_data_d;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    dirty_q <= dirty_q | wdiff;
                    if (handshake) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            frame_q <= frame_q + 16'd1;
                            state_q <= IDLE;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            data_q <= load_data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stream_valid_op = valid_q;
    assign stream_addr_op  = idx_q;
    assign stream_data_op  = data_q;
    assign stream_last_op  = valid_q && (idx_q == LAST_IDX);
    assign busy_op         = (state_q == SEND);
    assign dirty_op        = dirty_q;
    assign frame_count_op  = frame_q;

endmodule
